// File: rtl/traffic_controller.sv
// Per-round car spawn scheduler: spaces spawns per lane with LFSR-randomised gaps,
// grants at most one spawn per frame, and clears all cars at round end.
module traffic_controller #(
  parameter int unsigned NUM_LANES  = 4,
  parameter logic [9:0]  LANE_Y0    = 10'd120,
  parameter logic [9:0]  LANE_PITCH = 10'd32,
  parameter logic [7:0]  FIRST_GAP  = 8'd20,
  parameter logic [7:0]  MIN_GAP    = 8'd60,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                      FrameClk,
  input  logic                      Reset,
  input  logic                      RoundStart,
  input  logic                      RoundEnd,
  input  logic                      Pause,
  input  logic [1:0]                Difficulty,
  output logic [2*NUM_LANES-1:0]    SpawnEnable,
  output logic [4*NUM_LANES-1:0]    SlotType,
  output logic [6*NUM_LANES-1:0]    SlotSpeed,
  output logic [2*NUM_LANES-1:0]    SlotFaceLeft,
  output logic [20*NUM_LANES-1:0]   SlotSpawnX,
  output logic [20*NUM_LANES-1:0]   SlotSpawnY,
  output logic                      Busy
);

  localparam int unsigned NUM_SLOTS = 2 * NUM_LANES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [1:0]                diff_q, diff_d;
  logic [7:0]                timer_q [NUM_LANES];
  logic [7:0]                timer_d [NUM_LANES];
  logic [1:0]                fill_q  [NUM_LANES];
  logic [1:0]                fill_d  [NUM_LANES];
  logic [NUM_SLOTS-1:0]      en_q, en_d;
  logic [NUM_SLOTS-1:0]      face_q, face_d;
  logic [2*NUM_SLOTS-1:0]    type_q, type_d;
  logic [3*NUM_SLOTS-1:0]    spd_q, spd_d;
  logic [10*NUM_SLOTS-1:0]   x_q, x_d;
  logic [10*NUM_SLOTS-1:0]   y_q, y_d;

  logic                      grant;
  int unsigned               gl;
  int unsigned               sidx;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
  endfunction

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      diff_q  <= '0;
      timer_q <= '{default: '0};
      fill_q  <= '{default: '0};
      en_q    <= '0;
      face_q  <= '0;
      type_q  <= '0;
      spd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      diff_q  <= diff_d;
      timer_q <= timer_d;
      fill_q  <= fill_d;
      en_q    <= en_d;
      face_q  <= face_d;
      type_q  <= type_d;
      spd_q   <= spd_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    diff_d  = diff_q;
    timer_d = timer_q;
    fill_d  = fill_q;
    en_d    = en_q;
    face_d  = face_q;
    type_d  = type_q;
    spd_d   = spd_q;
    x_d     = x_q;
    y_d     = y_q;
    grant   = 1'b0;
    gl      = 0;
    sidx    = 0;
    case (state_q)
      S_IDLE: begin
        if (!RoundEnd && RoundStart) state_d = S_LOAD;
      end
      S_LOAD: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (RoundEnd) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          diff_d  = Difficulty;
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            timer_d[i] = 8'(FIRST_GAP * i);
            fill_d[i]  = '0;
          end
        end
      end
      S_RUN: begin
        if (RoundEnd) begin
          state_d = S_IDLE;
          en_d    = '0;
        end else if (!Pause) begin
          lfsr_d = lfsr_step(lfsr_q);
          // Expired lanes that lose arbitration keep timer 0 and retry next frame.
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (fill_q[i] < 2'd2) begin
              if (timer_q[i] == 8'd0) begin
                if (!grant) begin
                  grant = 1'b1;
                  gl    = i;
                end
              end else begin
                timer_d[i] = timer_q[i] - 8'd1;
              end
            end
          end
          if (grant) begin
            sidx               = 2 * gl + 32'(fill_q[gl]);
            en_d[sidx]         = 1'b1;
            type_d[2*sidx +: 2] = lfsr_q[1:0];
            spd_d[3*sidx +: 3]  = 3'd1 + {1'b0, diff_q} + {2'b00, gl[0]};
            face_d[sidx]        = ~gl[0];
            x_d[10*sidx +: 10]  = gl[0] ? 10'd51 : 10'd740;
            y_d[10*sidx +: 10]  = LANE_Y0 + 10'(LANE_PITCH * gl);
            fill_d[gl]          = fill_q[gl] + 2'd1;
            timer_d[gl]         = MIN_GAP + {2'b00, lfsr_q[5:0]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign SpawnEnable  = en_q;
  assign SlotType     = type_q;
  assign SlotSpeed    = spd_q;
  assign SlotFaceLeft = face_q;
  assign SlotSpawnX   = x_q;
  assign SlotSpawnY   = y_q;
  assign Busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: spawn-timing table plus a cycle-level scoreboard
// model for the default instance and a FIRST_GAP=0 instance for simultaneous expiry.
module tb_traffic_controller;

  logic        FrameClk = 1'b0;
  logic        Reset = 1'b1;
  logic        RoundStart = 1'b0, RoundEnd = 1'b0, Pause = 1'b0;
  logic [1:0]  Difficulty = 2'd2;

  logic [7:0]  en_a, face_a, en_b, face_b;
  logic [15:0] type_a, type_b;
  logic [23:0] spd_a, spd_b;
  logic [79:0] x_a, y_a, x_b, y_b;
  logic        busy_a, busy_b;

  traffic_controller dut (
    .FrameClk(FrameClk), .Reset(Reset), .RoundStart(RoundStart), .RoundEnd(RoundEnd),
    .Pause(Pause), .Difficulty(Difficulty), .SpawnEnable(en_a), .SlotType(type_a),
    .SlotSpeed(spd_a), .SlotFaceLeft(face_a), .SlotSpawnX(x_a), .SlotSpawnY(y_a),
    .Busy(busy_a));

  traffic_controller #(.FIRST_GAP(8'd0)) dut3 (
    .FrameClk(FrameClk), .Reset(Reset), .RoundStart(RoundStart), .RoundEnd(RoundEnd),
    .Pause(Pause), .Difficulty(Difficulty), .SpawnEnable(en_b), .SlotType(type_b),
    .SlotSpeed(spd_b), .SlotFaceLeft(face_b), .SlotSpawnX(x_b), .SlotSpawnY(y_b),
    .Busy(busy_b));

  always #5 FrameClk = ~FrameClk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
  endfunction

  // ---------------- scoreboard model of the default instance ----------------
  typedef struct {
    int         slot;
    logic [1:0] typ;
    logic [2:0] spd;
    logic       face;
    logic [9:0] x;
    logic [9:0] y;
  } ev_t;
  ev_t sb[$];

  int          m_state;  // 0 idle, 1 load, 2 run
  logic [15:0] m_lfsr;
  logic [1:0]  m_diff;
  logic [7:0]  m_timer [4];
  int          m_fill  [4];
  logic [7:0]  m_en;
  int          cyc = 0;

  task automatic model_reset();
    m_state = 0; m_lfsr = 16'hACE1; m_diff = 0; m_en = '0;
    for (int i = 0; i < 4; i++) begin m_timer[i] = 0; m_fill[i] = 0; end
    sb.delete();
  endtask

  task automatic model_clock();
    int g;
    ev_t e;
    if (m_state == 0) begin
      if (!RoundEnd && RoundStart) m_state = 1;
    end else if (m_state == 1) begin
      m_lfsr = lstep(m_lfsr);
      if (RoundEnd) m_state = 0;
      else begin
        m_state = 2; m_diff = Difficulty;
        for (int i = 0; i < 4; i++) begin m_timer[i] = 8'(20 * i); m_fill[i] = 0; end
      end
    end else if (RoundEnd) begin
      m_state = 0; m_en = '0;
    end else if (!Pause) begin
      g = -1;
      for (int i = 0; i < 4; i++)
        if (m_fill[i] < 2) begin
          if (m_timer[i] == 0) begin if (g < 0) g = i; end
          else m_timer[i] = m_timer[i] - 8'd1;
        end
      if (g >= 0) begin
        e.slot = 2 * g + m_fill[g];
        e.typ  = m_lfsr[1:0];
        e.spd  = 3'(1 + m_diff + (g % 2));
        e.face = (g % 2 == 0);
        e.x    = e.face ? 10'd740 : 10'd51;
        e.y    = 10'(120 + 32 * g);
        m_en[e.slot] = 1'b1;
        sb.push_back(e);
        m_fill[g]++;
        m_timer[g] = 8'(60 + m_lfsr[5:0]);
      end
      m_lfsr = lstep(m_lfsr);
    end
  endtask

  always @(posedge FrameClk) begin
    cyc++;
    if (!Reset) model_clock();
  end

  logic [7:0] prev_en = '0;
  int         first_at [4];
  bit         gap_en = 0;

  always @(negedge FrameClk) begin
    ev_t e;
    logic [7:0] rising;
    chk("spawn_enable", 32'(en_a), 32'(m_en));
    chk("busy", 32'(busy_a), 32'(m_state != 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_enable", 32'(en_a[e.slot]), 1);
      chk("sb_type", 32'(type_a[2*e.slot +: 2]), 32'(e.typ));
      chk("sb_speed", 32'(spd_a[3*e.slot +: 3]), 32'(e.spd));
      chk("sb_face", 32'(face_a[e.slot]), 32'(e.face));
      chk("sb_x", 32'(x_a[10*e.slot +: 10]), 32'(e.x));
      chk("sb_y", 32'(y_a[10*e.slot +: 10]), 32'(e.y));
    end
    rising = en_a & ~prev_en;
    for (int s = 0; s < 8; s++)
      if (rising[s]) begin
        if (s % 2 == 0) first_at[s/2] = cyc;
        else if (gap_en) begin
          // Reload is 60+lfsr[5:0] frames plus the expiry frame; arbitration can add up to 3.
          n_assert++;
          if (cyc - first_at[s/2] < 61 || cyc - first_at[s/2] > 127) begin
            n_fail++;
            $display("FAIL lane_gap lane %0d: got %0d expected 61..127", s / 2, cyc - first_at[s/2]);
          end
        end
      end
    prev_en = en_a;
  end

  // ---------------- spawn timing table ----------------
  typedef struct {
    int         which;  // 0 default instance, 1 FIRST_GAP=0 instance
    int         edge_n;
    int         slot;
    int         spd;
    logic       face;
    int         x;
    int         y;
    logic [7:0] mask;
  } vec_t;
  vec_t tbl[8];

  task automatic tick();
    @(posedge FrameClk);
    #2;
  endtask

  task automatic run_round();
    RoundStart = 1'b1;
    tick();
    RoundStart = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      for (int t = 0; t < 8; t++)
        if (tbl[t].edge_n == k) begin
          if (tbl[t].which == 0) begin
            chk("tbl_mask", 32'(en_a), 32'(tbl[t].mask));
            chk("tbl_speed", 32'(spd_a[3*tbl[t].slot +: 3]), tbl[t].spd);
            chk("tbl_face", 32'(face_a[tbl[t].slot]), 32'(tbl[t].face));
            chk("tbl_x", 32'(x_a[10*tbl[t].slot +: 10]), tbl[t].x);
            chk("tbl_y", 32'(y_a[10*tbl[t].slot +: 10]), tbl[t].y);
          end else begin
            chk("tbl3_mask", 32'(en_b), 32'(tbl[t].mask));
            chk("tbl3_speed", 32'(spd_b[3*tbl[t].slot +: 3]), tbl[t].spd);
            chk("tbl3_face", 32'(face_b[tbl[t].slot]), 32'(tbl[t].face));
            chk("tbl3_x", 32'(x_b[10*tbl[t].slot +: 10]), tbl[t].x);
            chk("tbl3_y", 32'(y_b[10*tbl[t].slot +: 10]), tbl[t].y);
          end
        end
    end
  endtask

  initial begin
    logic [15:0] sv_lfsr;
    logic [7:0]  sv_timer, sv_en;

    tbl[0] = '{0,  2, 0, 3, 1'b1, 740, 120, 8'h01};
    tbl[1] = '{0, 22, 2, 4, 1'b0,  51, 152, 8'h05};
    tbl[2] = '{0, 42, 4, 3, 1'b1, 740, 184, 8'h15};
    tbl[3] = '{0, 62, 6, 4, 1'b0,  51, 216, 8'h55};
    tbl[4] = '{1,  2, 0, 3, 1'b1, 740, 120, 8'h01};
    tbl[5] = '{1,  3, 2, 4, 1'b0,  51, 152, 8'h05};
    tbl[6] = '{1,  4, 4, 3, 1'b1, 740, 184, 8'h15};
    tbl[7] = '{1,  5, 6, 4, 1'b0,  51, 216, 8'h55};

    model_reset();
    tick();
    chk("reset_en", 32'(en_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    Reset = 1'b0;
    tick();

    // Default round timing and FIRST_GAP=0 back-to-back expiry
    run_round();

    // Pause freezes timers, LFSR and outputs; the model shifts later spawns by 50 frames
    Pause    = 1'b1;
    sv_lfsr  = dut.lfsr_q;
    sv_timer = dut.timer_q[1];
    sv_en    = en_a;
    repeat (50) begin
      tick();
      chk("pause_en", 32'(en_a), 32'(sv_en));
    end
    chk("pause_lfsr", 32'(dut.lfsr_q), 32'(sv_lfsr));
    chk("pause_timer1", 32'(dut.timer_q[1]), 32'(sv_timer));
    Pause = 1'b0;
    repeat (150) tick();

    // RoundEnd honoured while paused, then the round timing repeats
    Pause    = 1'b1;
    RoundEnd = 1'b1;
    tick();
    RoundEnd = 1'b0;
    chk("end_en", 32'(en_a), 0);
    chk("end_busy", 32'(busy_a), 0);
    chk("end_en3", 32'(en_b), 0);
    Pause  = 1'b0;
    gap_en = 1;
    run_round();

    // Lanes fill up over 600 frames
    repeat (530) tick();
    chk("fill_en", 32'(en_a), 32'h000000FF);
    chk("fill_en3", 32'(en_b), 32'h000000FF);

    // Asynchronous reset mid-RUN
    Reset = 1'b1;
    #1;
    chk("async_en", 32'(en_a), 0);
    chk("async_busy", 32'(busy_a), 0);
    chk("async_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    chk("async_en3", 32'(en_b), 0);
    model_reset();
    tick();
    Reset = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
